// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage.
// Contents:
//   - exception codes written to wb_ecode;
//   - bit positions inside the ms_exc and ms_csr_op flag vectors;
//   - the CSR index driven during ertn;
//   - the control part of a retire-buffer entry. The datapath fields
//     (pc, result, vaddr, rj, rkd, dest) depend on module parameters,
//     so the top packs them alongside this struct.
package wb_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;

    localparam int CSR_OP_RD   = 0;
    localparam int CSR_OP_WR   = 1;
    localparam int CSR_OP_XCHG = 2;
    localparam int CSR_OP_ERTN = 3;

    localparam logic [13:0] CSR_ERA = 14'h6;

    // gr_we sits at the LSB so that {gr_we, dest} forms one contiguous
    // field in the packed entry, which the buffer taps for hazard vectors.
    typedef struct packed {
        logic [13:0] csr_num;
        logic [3:0]  csr_op;
        logic [4:0]  exc;
        logic        gr_we;
    } wb_entry_ctrl_t;

endpackage

// File: rtl/wb_retire_fifo.sv
// Circular in-order buffer used as the retire queue.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, pop, flush  enqueue din / dequeue head / drop every entry
//   din               entry to enqueue
//   head              entry at the head (valid when count > 0)
//   count             number of occupied entries, 0..DEPTH
//   valid_vec         per-entry valid, index 0 = head
//   tap_vec           TAP_W-bit slice at TAP_LSB of every entry, index 0 = head
module wb_retire_fifo #(
    parameter int W       = 8,
    parameter int DEPTH   = 2,
    parameter int TAP_LSB = 0,
    parameter int TAP_W   = 1,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [CNT_W-1:0]       count,
    output logic [DEPTH-1:0]       valid_vec,
    output logic [DEPTH*TAP_W-1:0] tap_vec
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr, tail_ptr;
    logic [PTR_W:0]   rot_idx;
    logic [W-1:0]     ent;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= ptr_inc(tail_ptr);
            if (pop)  head_ptr <= ptr_inc(head_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[tail_ptr] <= din;
    end

    assign head = mem[head_ptr];

    // Present entries rotated so that index 0 is always the head.
    always_comb begin
        valid_vec = '0;
        tap_vec   = '0;
        rot_idx   = '0;
        ent       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rot_idx = {1'b0, head_ptr} + (PTR_W + 1)'(i);
            if (rot_idx >= (PTR_W + 1)'(DEPTH)) rot_idx = rot_idx - (PTR_W + 1)'(DEPTH);
            ent = mem[rot_idx[PTR_W-1:0]];
            valid_vec[i] = CNT_W'(i) < count;
            tap_vec[i*TAP_W +: TAP_W] = ent[TAP_LSB +: TAP_W];
        end
    end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: a DEPTH-entry in-order retire buffer between the
// memory stage and a stallable register-file write port. Exceptions,
// interrupts and ertn are resolved at the buffer head and flush the buffer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ms_to_ws_valid/ws_allowin  handshake with the memory stage
//   ms_*                       instruction fields captured on push
//   rf_stall                   register-file port busy this cycle
//   has_int                    pending interrupt
//   csr_rvalue                 combinational CSR read data for csr_num
//   csr_*                      CSR index / write strobe / mask / value
//   wb_ex, wb_ecode, wb_vaddr  exception commit pulse and cause
//   wb_pc, wb_ertn             head PC, ertn commit pulse
//   rf_we, rf_waddr, rf_wdata  GPR write port
//   pend_we_vec, pend_dest_vec per-entry pending destinations (entry0 = head)
//   retire_cnt                 retired-instruction counter
module wb_retire_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ms_to_ws_valid,
    output logic                     ws_allowin,
    input  logic [DATA_W-1:0]        ms_pc,
    input  logic                     ms_gr_we,
    input  logic [RADDR_W-1:0]       ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic [4:0]               ms_exc,
    input  logic [DATA_W-1:0]        ms_vaddr,
    input  logic [3:0]               ms_csr_op,
    input  logic [13:0]              ms_csr_num,
    input  logic [DATA_W-1:0]        ms_rj,
    input  logic [DATA_W-1:0]        ms_rkd,
    input  logic                     rf_stall,
    input  logic                     has_int,
    input  logic [DATA_W-1:0]        csr_rvalue,
    output logic [13:0]              csr_num,
    output logic                     csr_we,
    output logic [DATA_W-1:0]        csr_wmask,
    output logic [DATA_W-1:0]        csr_wvalue,
    output logic                     wb_ex,
    output logic [5:0]               wb_ecode,
    output logic [DATA_W-1:0]        wb_vaddr,
    output logic [DATA_W-1:0]        wb_pc,
    output logic                     wb_ertn,
    output logic                     rf_we,
    output logic [RADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [DEPTH-1:0]         pend_we_vec,
    output logic [DEPTH*RADDR_W-1:0] pend_dest_vec,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int CTRL_W   = $bits(wb_entry_ctrl_t);
    localparam int DEST_LSB = 5 * DATA_W;
    localparam int ENTRY_W  = DEST_LSB + RADDR_W + CTRL_W;
    localparam int TAP_W    = RADDR_W + 1;
    localparam int FCNT_W   = $clog2(DEPTH + 1);

    wb_entry_ctrl_t        in_ctrl, h_ctrl;
    logic [ENTRY_W-1:0]    in_entry, head;
    logic [FCNT_W-1:0]     fifo_count;
    logic [DEPTH-1:0]      valid_vec;
    logic [DEPTH*TAP_W-1:0] tap_vec;
    logic [DATA_W-1:0]     h_pc, h_result, h_vaddr, h_rj, h_rkd;
    logic [RADDR_W-1:0]    h_dest;
    logic                  head_valid, take_ex, take_ertn, retire_ok, normal_ret;
    logic                  flush, push;
    logic [CNT_W-1:0]      cnt_q;

    assign in_ctrl  = '{csr_num: ms_csr_num, csr_op: ms_csr_op, exc: ms_exc, gr_we: ms_gr_we};
    assign in_entry = {in_ctrl, ms_dest, ms_pc, ms_result, ms_vaddr, ms_rj, ms_rkd};
    assign {h_ctrl, h_dest, h_pc, h_result, h_vaddr, h_rj, h_rkd} = head;

    // Gating with reset keeps every strobe low while reset is held.
    assign head_valid = valid_vec[0] && !reset;
    assign take_ex    = head_valid && (has_int || (|h_ctrl.exc));
    assign take_ertn  = head_valid && h_ctrl.csr_op[CSR_OP_ERTN] && !take_ex;
    assign retire_ok  = head_valid && (take_ex || take_ertn || !rf_stall);
    assign normal_ret = retire_ok && !take_ex && !take_ertn;
    assign flush      = take_ex || take_ertn;

    assign ws_allowin = (fifo_count != FCNT_W'(DEPTH)) || retire_ok;
    assign push       = ms_to_ws_valid && ws_allowin && !flush;

    wb_retire_fifo #(
        .W       (ENTRY_W),
        .DEPTH   (DEPTH),
        .TAP_LSB (DEST_LSB),
        .TAP_W   (TAP_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (normal_ret),
        .flush     (flush),
        .din       (in_entry),
        .head      (head),
        .count     (fifo_count),
        .valid_vec (valid_vec),
        .tap_vec   (tap_vec)
    );

    assign wb_ex   = take_ex;
    assign wb_ertn = take_ertn;
    assign wb_pc   = h_pc;

    assign rf_we    = normal_ret && h_ctrl.gr_we;
    assign rf_waddr = h_dest;
    assign rf_wdata = (|h_ctrl.csr_op[CSR_OP_XCHG:CSR_OP_RD]) ? csr_rvalue : h_result;

    // During ertn the CSR read port is pointed at ERA for the return address.
    assign csr_num    = (head_valid && h_ctrl.csr_op[CSR_OP_ERTN]) ? CSR_ERA : h_ctrl.csr_num;
    assign csr_we     = normal_ret && (h_ctrl.csr_op[CSR_OP_WR] || h_ctrl.csr_op[CSR_OP_XCHG]);
    assign csr_wvalue = h_rkd;

    always_comb begin
        csr_wmask = '0;
        if (h_ctrl.csr_op[CSR_OP_WR])        csr_wmask = '1;
        else if (h_ctrl.csr_op[CSR_OP_XCHG]) csr_wmask = h_rj;
    end

    always_comb begin
        wb_ecode = ECODE_INT;
        wb_vaddr = '0;
        if (has_int) begin
            wb_ecode = ECODE_INT;
        end else if (h_ctrl.exc[EXC_ADEF]) begin
            wb_ecode = ECODE_ADEF;
            wb_vaddr = h_pc;
        end else if (h_ctrl.exc[EXC_INE]) begin
            wb_ecode = ECODE_INE;
        end else if (h_ctrl.exc[EXC_SYS]) begin
            wb_ecode = ECODE_SYS;
        end else if (h_ctrl.exc[EXC_BRK]) begin
            wb_ecode = ECODE_BRK;
        end else if (h_ctrl.exc[EXC_ALE]) begin
            wb_ecode = ECODE_ALE;
            wb_vaddr = h_vaddr;
        end
    end

    always_comb begin
        pend_we_vec   = '0;
        pend_dest_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_we_vec[i] = valid_vec[i] && tap_vec[i*TAP_W + RADDR_W];
            pend_dest_vec[i*RADDR_W +: RADDR_W] = tap_vec[i*TAP_W +: RADDR_W];
        end
    end

    // Exceptions do not count as retired; ertn does.
    always_ff @(posedge clk) begin
        if (reset)                         cnt_q <= '0;
        else if (normal_ret || take_ertn)  cnt_q <= cnt_q + 1'b1;
    end

    assign retire_cnt = cnt_q;

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
Parametrised writeback/retire stage for the 5-stage LoongArch pipeline and successor to the single-entry writeback stage. A DEPTH-entry in-order retire buffer decouples the memory stage from a stallable register-file write port. The stage:
- retires at most one instruction per cycle;
- resolves exceptions, interrupts and ertn at the buffer head by fixed priority;
- drives the CSR write/read interface;
- exposes per-entry pending-destination vectors for hazard detection;
- keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath/PC width
RADDR_W, 5, register-file address width
DEPTH, 2, retire buffer entries (legal 1..4)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  reset
ms_to_ws_valid  in  1  memory stage has an instruction
ws_allowin  out  1  stage accepts this cycle
ms_pc  in  DATA_W  instruction PC
ms_gr_we  in  1  writes GPR
ms_dest  in  RADDR_W  destination register
ms_result  in  DATA_W  ALU/load result
ms_exc  in  5  exception flags {ale,brk,sys,ine,adef} (bit0=adef)
ms_vaddr  in  DATA_W  faulting data address (ALE)
ms_csr_op  in  4  {ertn,csrxchg,csrwr,csrrd} (bit0=csrrd)
ms_csr_num  in  14  CSR number
ms_rj  in  DATA_W  csrxchg mask
ms_rkd  in  DATA_W  CSR write value
rf_stall  in  1  register-file port busy this cycle
has_int  in  1  pending interrupt from CSR unit
csr_rvalue  in  DATA_W  CSR read data (combinational)
csr_num  out  14  CSR index (0x6 during ertn)
csr_we  out  1  CSR write strobe
csr_wmask  out  DATA_W  write mask
csr_wvalue  out  DATA_W  write value
wb_ex  out  1  exception commit pulse
wb_ecode  out  6  exception code
wb_vaddr  out  DATA_W  BADV value
wb_pc  out  DATA_W  PC of head entry
wb_ertn  out  1  ertn commit pulse
rf_we  out  1  GPR write
rf_waddr  out  RADDR_W  GPR address
rf_wdata  out  DATA_W  GPR data
pend_we_vec  out  DEPTH  valid&gr_we per entry
pend_dest_vec  out  DEPTH*RADDR_W  dest per entry (entry0 at LSBs, entry0=head)
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
Reset and buffer:
- Reset (sync, active-high) clears the buffer and all valid bits, and sets retire_cnt=0.
- All strobes (wb_ex, wb_ertn, rf_we, csr_we) are 0 during and after reset until an entry retires.
- Buffer is a circular FIFO with head/tail pointers and a count of 0..DEPTH.
- ws_allowin = (count<DEPTH) || retire_ok, evaluated combinationally in the same cycle.
- Push happens when ms_to_ws_valid && ws_allowin && !flush. Capture into the entry occurs at the clock edge; the entry is eligible to retire the next cycle (minimum latency 1).

Head entry classification (combinational when count>0):
- Exception priority: INT (ecode 0x0, when has_int) > ADEF 0x8 > INE 0xd > SYS 0xb > BRK 0xc > ALE 0x9.
- take_ex = head_valid && (has_int || |exc).
- take_ertn = head_valid && ertn && !take_ex.
- wb_vaddr = head PC for ADEF, ms_vaddr captured value for ALE, else 0.

Retirement:
- retire_ok = head_valid && (take_ex || take_ertn || !rf_stall).
- Exception and ertn do not wait on rf_stall.
- Normal retire:
  - rf_we = gr_we.
  - rf_wdata = csr_rvalue if any csr op, else result.
  - csr_we = csrwr|csrxchg; wmask = all-ones for csrwr, rj for csrxchg, else 0.
  - Pop head; retire_cnt += 1 (wraps at 2^CNT_W).
- take_ex: wb_ex=1 for exactly one cycle.
  - rf_we=0 and csr_we=0.
  - flush = 1: the whole buffer is cleared at the edge, the same-cycle push is dropped, and retire_cnt is unchanged.
- take_ertn: wb_ertn=1 for one cycle.
  - csr_num=0x6 so csr_rvalue=ERA.
  - Flush identically to take_ex; retire_cnt += 1.
- Pulses are never asserted with count=0.

Stall and simultaneous events:
- rf_stall with a normal head: nothing retires, outputs hold, pushes continue until full.
- Full && retire_ok && push in the same cycle: pop and push both occur and count is unchanged.
- has_int rising while head is stalled: the interrupt is taken that cycle (int beats stall).

Hazard vectors:
- pend_we_vec[i] = entry i valid && gr_we, with i relative to head.

Decomposition:
- Shared package wb_pkg holds:
  - ecode constants (INT, ADEF, INE, SYS, BRK, ALE);
  - exc-flag and csr_op bit indices;
  - CSR_ERA = 14'h6;
  - the retire-entry struct typedef.
- One sub-module is natural: wb_retire_fifo, a parametrised circular buffer with head peek, count and pointer logic. Classification and CSR logic live in the top.

Test Plan:
- Reset then push addi (pc 0x1c000000, dest 4, result 0x5) -> next cycle rf_we=1, rf_waddr=4, rf_wdata=0x5, retire_cnt=1.
- DEPTH=2, rf_stall=1, push 3 instrs -> ws_allowin=0 after 2 pushes; drop rf_stall -> retire one per cycle in order and retire_cnt=3.
- Head with exc=adef plus sys (pc 0x1c000010), buffer holding 1 more -> wb_ex=1, ecode=0x8, wb_vaddr=0x1c000010, rf_we=0; next cycle count=0; same-cycle push dropped.
- csrxchg rj=0x0000ff00, rkd=0x12345678, csr_rvalue=0xaaaa5555 -> csr_we=1, wmask=0x0000ff00, rf_wdata=0xaaaa5555.
- ertn at head with rf_stall=1 -> wb_ertn=1 same cycle, csr_num=0x6, buffer flushed, retire_cnt+1.
- has_int asserted with a stalled normal head -> wb_ex=1, ecode=0x0, no GPR write; counter wrap check with CNT_W=4: 16 retires -> retire_cnt=0.
